// File: rtl/mem_access_stage.sv
// MEM stage: drains EX/MEM, runs one data-memory access per op over req/ack.
// Optional BUSY-cycle abort compiled in with MEM_STAGE_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    W_in,
  input  logic [1:0]    M_in,
  input  logic [DW-1:0] ALU_in,
  input  logic [DW-1:0] RD2_in,
  input  logic [4:0]    WN_in,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [1:0]    W_out,
  output logic [DW-1:0] RD_out,
  output logic [DW-1:0] ALU_out,
  output logic [4:0]    WN_out,
  output logic [DW-1:0] WB_data,
  output logic          err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [1:0]    w_lat_q, w_lat_d;
  logic [4:0]    wn_lat_q, wn_lat_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [1:0]    w_out_q, w_out_d;
  logic [DW-1:0] rd_out_q, rd_out_d;
  logic [DW-1:0] alu_out_q, alu_out_d;
  logic [4:0]    wn_out_q, wn_out_d;
  logic          stall_c;
  logic          timeout;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == BUSY) && !dmem_ack &&
                   (cnt_q == CW'(TIMEOUT - 1));

  // Held at zero in IDLE, so every BUSY entry starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (!dmem_ack)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    w_lat_d   = w_lat_q;
    wn_lat_d  = wn_lat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    w_out_d   = w_out_q;
    rd_out_d  = rd_out_q;
    alu_out_d = alu_out_q;
    wn_out_d  = wn_out_q;
    stall_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (M_in == 2'b00) begin
          w_out_d   = W_in;
          alu_out_d = ALU_in;
          wn_out_d  = WN_in;
          rd_out_d  = '0;
        end else begin
          stall_c  = 1'b1;
          addr_d   = ALU_in;
          wdata_d  = RD2_in;
          w_lat_d  = W_in;
          wn_lat_d = WN_in;
          we_d     = M_in[0];
          w_out_d  = 2'b00;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          w_out_d   = w_lat_q;
          alu_out_d = addr_q;
          wn_out_d  = wn_lat_q;
          rd_out_d  = we_q ? '0 : dmem_rdata;
          state_d   = IDLE;
        end else if (timeout) begin
          w_out_d = 2'b00;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          w_out_d = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      w_lat_q   <= '0;
      wn_lat_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      w_out_q   <= '0;
      rd_out_q  <= '0;
      alu_out_q <= '0;
      wn_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      w_lat_q   <= w_lat_d;
      wn_lat_q  <= wn_lat_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      w_out_q   <= w_out_d;
      rd_out_q  <= rd_out_d;
      alu_out_q <= alu_out_d;
      wn_out_q  <= wn_out_d;
    end
  end

  // Reset must kill the handshake at once, even with M_in still asserted.
  assign stall      = stall_c & ~rst;
  assign dmem_req   = (state_q == BUSY) & ~rst;
  assign err        = timeout & ~rst;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign W_out      = w_out_q;
  assign RD_out     = rd_out_q;
  assign ALU_out    = alu_out_q;
  assign WN_out     = wn_out_q;
  assign WB_data    = w_out_q[0] ? rd_out_q : alu_out_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: directed cases plus random ops
// against an architectural memory model; timeout cases with MEM_STAGE_TIMEOUT_EN.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  W_in = '0, M_in = '0;
  logic [31:0] ALU_in = '0, RD2_in = '0;
  logic [4:0]  WN_in = '0;
  logic        stall, dmem_req, dmem_we, err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [1:0]  W_out;
  logic [31:0] RD_out, ALU_out, WB_data;
  logic [4:0]  WN_out;

  mem_access_stage #(.DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .W_in(W_in), .M_in(M_in), .ALU_in(ALU_in),
    .RD2_in(RD2_in), .WN_in(WN_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .W_out(W_out), .RD_out(RD_out), .ALU_out(ALU_out),
    .WN_out(WN_out), .WB_data(WB_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  w;
    logic [31:0] alu;
    logic [4:0]  wn;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] dev_mem[logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          dev_en = 1'b1;
  bit          spur_en = 1'b0;
  int          wait_cnt = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_2468;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  // Memory device: acks after wait_cnt BUSY cycles, sometimes acks while idle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (dev_en) begin
        dmem_ack = 1'b0;
        if (dmem_req) begin
          if (wait_cnt == 0) begin
            dmem_ack = 1'b1;
            if (dmem_we) begin
              dev_mem[dmem_addr] = dmem_wdata;
              dmem_rdata = $urandom;
            end else begin
              dmem_rdata = dev_read(dmem_addr);
            end
            wait_cnt = $urandom_range(0, 3);
          end else begin
            wait_cnt--;
          end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
          dmem_ack   = 1'b1;
          dmem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: every non-bubble MEM/WB result retires one expected entry.
  exp_t me;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
`ifndef MEM_STAGE_TIMEOUT_EN
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif
        if (W_out != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", {30'd0, W_out}, 32'd0);
          end else begin
            me = exp_q.pop_front();
            chk("W_out", {30'd0, W_out}, {30'd0, me.w});
            chk("ALU_out", ALU_out, me.alu);
            chk("WN_out", {27'd0, WN_out}, {27'd0, me.wn});
            chk("RD_out", RD_out, me.rd);
            chk("WB_data", WB_data, me.w[0] ? me.rd : me.alu);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "simulation bound expired");
  end

  int          ns, nr;
  logic [31:0] sa, sd;
  logic        swe, serr;

  task automatic issue(input logic [1:0] w, input logic [1:0] m,
                       input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [4:0] wn);
    exp_t e;
    bit   done, st;
    e.w = w; e.alu = alu; e.wn = wn;
    if (m == 2'b00) e.rd = '0;
    else if (m[0]) begin
      ref_mem[alu] = rd2;
      e.rd = '0;
    end else e.rd = ref_read(alu);
    exp_q.push_back(e);
    W_in = w; M_in = m; ALU_in = alu; RD2_in = rd2; WN_in = wn;
    ns = 0; nr = 0; sa = '0; sd = '0; swe = 1'b0; serr = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (dmem_req) begin
        nr++;
        sa = dmem_addr; sd = dmem_wdata; swe = dmem_we;
      end
      if (err) serr = 1'b1;
      st = stall;
      if (st) ns++;
      @(posedge clk);
      if (!st) done = 1'b1;
    end
    chk("op_accepted", {31'd0, done}, 32'd1);
    #1;
    W_in = '0; M_in = '0;
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk({tag, "_W_out"}, {30'd0, W_out}, 32'd0);
    chk({tag, "_RD_out"}, RD_out, 32'd0);
    chk({tag, "_ALU_out"}, ALU_out, 32'd0);
    chk({tag, "_WN_out"}, {27'd0, WN_out}, 32'd0);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    reset_check("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b11, 2'b00, 32'h5555, 32'h0, 5'd2);

    // Reset mid-run, then a plain register pass-through.
    #2;
    reset_check("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
    chk("t1_stall", ns, 0);
    chk("t1_W_out", {30'd0, W_out}, 32'd2);
    chk("t1_ALU_out", ALU_out, 32'h1234);
    chk("t1_WN_out", {27'd0, WN_out}, 32'd5);
    chk("t1_RD_out", RD_out, 32'd0);

    // Load with ack in the 4th BUSY cycle.
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    dev_mem[32'h40] = 32'hDEAD_BEEF;
    wait_cnt = 3;
    issue(2'b11, 2'b10, 32'h40, 32'h0, 5'd7);
    chk("t2_stall_cycles", ns, 4);
    chk("t2_req_cycles", nr, 4);
    chk("t2_addr", sa, 32'h40);
    chk("t2_we", {31'd0, swe}, 32'd0);
    chk("t2_RD_out", RD_out, 32'hDEAD_BEEF);
    chk("t2_WB_data", WB_data, 32'hDEAD_BEEF);

    // Store acked in the first BUSY cycle.
    wait_cnt = 0;
    issue(2'b10, 2'b01, 32'h80, 32'hA5A5_A5A5, 5'd9);
    chk("t3_latency", ns + 1, 2);
    chk("t3_req_cycles", nr, 1);
    chk("t3_we", {31'd0, swe}, 32'd1);
    chk("t3_wdata", sd, 32'hA5A5_A5A5);
    chk("t3_RD_out", RD_out, 32'd0);
    wait_cnt = 1;
    issue(2'b11, 2'b10, 32'h80, 32'h0, 5'd10);
    chk("t3_readback", RD_out, 32'hA5A5_A5A5);

    // Random traffic, M_in==11 included, spurious idle acks on.
    spur_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  w, m;
      logic [31:0] a;
      w = 2'($urandom_range(1, 3));
      m = 2'($urandom_range(0, 3));
      a = (m == 2'b00) ? $urandom : {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      issue(w, m, a, $urandom, 5'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    spur_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while BUSY, then an ack after release must be ignored.
    dev_en = 1'b0;
    dmem_ack = 1'b0;
    W_in = 2'b11; M_in = 2'b10; ALU_in = 32'h44; WN_in = 5'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t4_req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t4_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("t4_stall_drop", {31'd0, stall}, 32'd0);
    W_in = '0; M_in = '0;
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    chk("t4_ack_ignored_W", {30'd0, W_out}, 32'd0);
    chk("t4_ack_ignored_RD", RD_out, 32'd0);
    chk("t4_still_idle", {31'd0, dmem_req}, 32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Never-acked load aborts on the 4th BUSY cycle.
    W_in = 2'b11; M_in = 2'b10; ALU_in = 32'h48; WN_in = 5'd4;
    @(posedge clk);
    #1;
    W_in = '0; M_in = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t5_err", {31'd0, err}, (k == 4) ? 32'd1 : 32'd0);
      chk("t5_stall", {31'd0, stall}, (k == 4) ? 32'd0 : 32'd1);
      @(posedge clk);
    end
    #1;
    chk("t5_W_out", {30'd0, W_out}, 32'd0);
    chk("t5_idle", {31'd0, dmem_req}, 32'd0);
    chk("t5_err_clear", {31'd0, err}, 32'd0);
    // Ack on the 4th cycle beats the abort.
    dev_en = 1'b1;
    wait_cnt = 3;
    issue(2'b11, 2'b10, 32'h48, 32'h0, 5'd4);
    chk("t5_ack_err", {31'd0, serr}, 32'd0);
    chk("t5_ack_stall", ns, 4);
    chk("t5_ack_RD", RD_out, ref_read(32'h48));
`endif

    dev_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
